// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives a one-cycle-latency imem and
// buffers {instr, pc, pc+4} in a FIFO for decode. Optional FETCH_PERF_EN adds a stall counter.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic [31:0]              imem_instr_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [31:0]              dec_instr_o,
  output logic [31:0]              dec_pc_o,
  output logic [31:0]              dec_pc4_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              stall_cycles_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];

  logic          req, push, pop, valid;
  logic [CW:0]   credits_used;

  // Outstanding request reserves a slot, so a response can always be pushed.
  assign credits_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign req   = rst_i & ~redirect_i & (credits_used < (CW+1)'(DEPTH));
  assign valid = (count_q != '0);
  assign pop   = valid & dec_ready_i;
  assign push  = inflight_q & ~redirect_i;

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    count_d       = count_q;

    if (req) begin
      fpc_d         = fpc_q + 32'd4;
      inflight_pc_d = fpc_q;
    end
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push) wptr_d = wptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (redirect_i) begin
      fpc_d      = redirect_pc_i & ~32'h3;
      inflight_d = 1'b0;
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wptr_q] <= imem_instr_i;
      pc_mem_q[wptr_q]    <= inflight_pc_q;
      pc4_mem_q[wptr_q]   <= inflight_pc_q + 32'd4;
    end
  end

  // Head data is gated by valid so an empty queue (incl. reset) presents zeros.
  assign imem_req_o  = req;
  assign imem_addr_o = fpc_q;
  assign dec_valid_o = valid;
  assign dec_instr_o = valid ? instr_mem_q[rptr_q] : '0;
  assign dec_pc_o    = valid ? pc_mem_q[rptr_q]    : '0;
  assign dec_pc4_o   = valid ? pc4_mem_q[rptr_q]   : '0;
  assign count_o     = count_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (rst_i & ~redirect_i & ~req) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic, checked every
// cycle against a transaction-level queue model of the fetch stage.
module tb_instr_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk_i;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_pc4_o;
  logic [$clog2(DEPTH):0] count_o;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles_o;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o),
    .dec_pc4_o     (dec_pc4_o),
    .count_o       (count_o)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles_o(stall_cycles_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int unsigned ntot;
  int unsigned npass;

  // Reference model: queue of buffered PCs, one outstanding fetch, fetch PC.
  logic [31:0] mq[$];
  int unsigned pend;
  logic [31:0] pend_pc;
  logic [31:0] mfpc;
  logic [31:0] mstall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic rdy, input logic redir, input logic [31:0] rpc,
                            input logic req);
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (redir) begin
      mq.delete();
      pend = 0;
      mfpc = rpc & ~32'h3;
    end else begin
      if (pend != 0) mq.push_back(pend_pc);
      if (!req) mstall = mstall + 32'd1;
      pend = req ? 1 : 0;
      if (req) begin
        pend_pc = mfpc;
        mfpc    = mfpc + 32'd4;
      end
    end
  endtask

  // Entered just after a falling edge; leaves at the next falling edge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic        ereq;
    logic [31:0] eaddr;
    dec_ready_i   = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    ereq  = !redir && ((mq.size() + pend) < DEPTH);
    eaddr = mfpc;
    chk("imem_req", 32'(imem_req_o), 32'(ereq));
    chk("imem_addr", imem_addr_o, eaddr);
    chk("dec_valid", 32'(dec_valid_o), 32'(mq.size() != 0));
    chk("count", 32'(count_o), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("dec_pc", dec_pc_o, mq[0]);
      chk("dec_pc4", dec_pc4_o, mq[0] + 32'd4);
      chk("dec_instr", dec_instr_o, mq[0] ^ KEY);
    end
`ifdef FETCH_PERF_EN
    chk("stall_cycles", stall_cycles_o, mstall);
`endif
    @(posedge clk_i);
    model_edge(rdy, redir, rpc, ereq);
    #1 imem_instr_i = ereq ? (eaddr ^ KEY) : $urandom();
    @(negedge clk_i);
  endtask

  // Half-cycle active-low reset pulse starting at a falling edge.
  task automatic rst_pulse();
    rst_i      = 1'b0;
    redirect_i = 1'b0;
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_instr", dec_instr_o, 32'd0);
    chk("rst_pc", dec_pc_o, 32'd0);
    chk("rst_pc4", dec_pc4_o, 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);
`ifdef FETCH_PERF_EN
    chk("rst_stall", stall_cycles_o, 32'd0);
`endif
    mq.delete();
    pend   = 0;
    mfpc   = RESET_PC;
    mstall = '0;
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    model_edge(dec_ready_i, 1'b0, 32'd0, 1'b1);
    #1 imem_instr_i = RESET_PC ^ KEY;
    @(negedge clk_i);
  endtask

  initial begin
    ntot = 0; npass = 0;
    pend = 0; pend_pc = '0; mfpc = RESET_PC; mstall = '0;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    dec_ready_i = 1'b0; imem_instr_i = '0;
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    rst_pulse();

    // Decode stalled: queue fills to DEPTH after exactly DEPTH requests.
    repeat (10) step(1'b0, 1'b0, 32'd0);
    // Redirect while full; target low bits dropped.
    step(1'b0, 1'b1, 32'h0000_0103);
    repeat (2) step(1'b0, 1'b0, 32'd0);
    repeat (6) step(1'b1, 1'b0, 32'd0);
    // Redirect coinciding with a handshake and a pending response.
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (4) step(1'b1, 1'b0, 32'd0);
    // Fetch PC wrap across 2^32.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) step(1'b1, 1'b0, 32'd0);
    // Mid-stream reset pulse, then refetch from RESET_PC.
    rst_pulse();
    repeat (5) step(1'b1, 1'b0, 32'd0);
    // Back-to-back redirects: the last wins.
    step(1'b1, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 32'h0000_0080);
    repeat (4) step(1'b1, 1'b0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst_pulse();
      step(($urandom() % 4) != 0, ($urandom() % 12) == 0, $urandom());
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage placed directly upstream of the single-cycle decode/execute datapath. Owns the fetch PC and drives a synchronous instruction memory with one-cycle read latency. Buffers returned instructions with their PC and PC+4 in a small FIFO, and hands them to decode over a valid/ready handshake. A redirect input (taken branch, j/jal/jr) flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- redirect_i  in  1  flush queue and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req_o  out  1  fetch request this cycle
- imem_addr_o  out  32  fetch address, word aligned
- imem_instr_i  in  32  instruction for the request issued in the previous cycle
- dec_valid_o  out  1  head entry valid
- dec_ready_i  in  1  decode accepts head entry
- dec_instr_o  out  32  head instruction
- dec_pc_o  out  32  head PC
- dec_pc4_o  out  32  head PC+4
- count_o  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Registers: fpc (next fetch address), inflight bit plus inflight_pc, FIFO with read and write pointers plus occupancy.
- Request rule: imem_req_o = rst_i & ~redirect_i & (count + inflight < DEPTH). This credit check guarantees every response has a free slot.
  - imem_addr_o = fpc.
  - On a request, fpc <= fpc + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 -> 0).
  - inflight <= request; inflight_pc <= fpc.
- Response: when inflight is set and no redirect occurs this cycle, push {imem_instr_i, inflight_pc, inflight_pc+4} at the end of the cycle.
- Pop: dec_valid_o & dec_ready_i advances the read pointer.
- Push and pop in the same cycle leave occupancy unchanged.
- dec_* outputs are the head entry, read combinationally from the FIFO.
- dec_valid_o = (count != 0).
- dec_instr_o, dec_pc_o and dec_pc4_o hold their value while dec_valid_o is high and ready is low.
- Redirect (highest priority), in one cycle:
  - a handshake in the same cycle completes (decode consumed the head);
  - all FIFO entries are then discarded and the pending response is killed (not pushed);
  - inflight <= 0; fpc <= {redirect_pc_i[31:2], 2'b00};
  - imem_req_o is forced 0 that cycle.
- Back-to-back redirects: the last one wins; each one re-flushes.
- Operating states: an implicit 2-state run condition, STALL (credits exhausted, no request) and FETCH. It needs no explicit FSM beyond the inflight bit.

## Timing
- Reset (async, while rst_i=0):
  - fpc=RESET_PC; inflight=0; pointers=0; count_o=0;
  - dec_valid_o=0; imem_req_o=0;
  - dec_instr_o/dec_pc_o/dec_pc4_o = 0;
  - imem_addr_o=RESET_PC.
- Reset asserted mid-operation drops all state immediately. A response arriving after deassertion is ignored because inflight=0.
- Cycle 0 is the first cycle after deassertion:
  - request RESET_PC;
  - cycle 1: response pushed at end of cycle;
  - cycle 2: dec_valid_o=1 with dec_pc_o=RESET_PC.
- Steady state with dec_ready_i=1: one instruction per cycle, no bubbles.
- Redirect in cycle t:
  - dec_valid_o=0 in t+1;
  - request at the target in t+1;
  - dec_valid_o=1 with the target in t+3.
- Full (count=DEPTH, or count=DEPTH-1 with inflight set): no request. A pop re-enables the request in the following cycle.

## Configuration
- FETCH_PERF_EN defined:
  - adds output port stall_cycles_o (32 bits);
  - counts cycles with rst_i=1, redirect_i=0 and imem_req_o=0 (credit stalls);
  - wraps at 2^32;
  - resets to 0 and is not cleared by redirect.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset release, dec_ready_i=1, imem returns addr^32'hA5A5_0000 -> dec_pc_o = 0,4,8,... from cycle 2 on every cycle; dec_pc4_o = dec_pc_o+4.
- dec_ready_i=0 for 10 cycles, DEPTH=4 -> count_o reaches 4; exactly 4 requests issued after reset, then imem_req_o=0; head stays PC 0. With FETCH_PERF_EN, stall_cycles_o=6.
- Queue full, then redirect_i=1 with redirect_pc_i=32'h0000_0103 -> next cycle count_o=0, dec_valid_o=0, imem_addr_o=32'h0000_0100; dec_pc_o=32'h100 two cycles later.
- Redirect in the same cycle as a handshake and a pending response -> head is consumed, the response is not pushed, and the next delivered PC is the target.
- fpc=32'hFFFF_FFF8 via redirect -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; dec_pc4_o of FFFF_FFFC is 0.
- rst_i pulsed low for half a cycle mid-stream -> outputs clear immediately; refetch starts at RESET_PC; no stale instruction appears.
